b16_io_responder: RTL and testbench

- Memory-mapped I/O responder on the b16 CPU bus, decoding the top I/O page (BASE..BASE+3, default 0xFFFC–0xFFFF).
- Bridges CPU word accesses to a byte-stream serial core: TX FIFO toward the UART transmitter, RX FIFO from the UART receiver.
- Drives the CPU bus read data and a ready/stall signal that the top ANDs into the CPU run enable.
- Replaces the unused I/O select path in the top level.

---
 rtl/b16_io_responder_pkg.sv | 22 ++
 rtl/b16_io_responder_fifo.sv | 61 ++++++
 rtl/b16_io_responder.sv | 141 ++++++++++++++
 tb/tb_b16_io_responder.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/b16_io_responder_pkg.sv
// Shared definitions for the b16 I/O responder: register offsets, STATUS bit
// positions and the default window base.
package b16_io_responder_pkg;

    localparam logic [15:0] BASE_DEFAULT = 16'hFFFC;

    localparam logic [1:0] OFS_DATA   = 2'd0;
    localparam logic [1:0] OFS_STATUS = 2'd2;

    localparam int ST_RX_NONEMPTY = 0;
    localparam int ST_TX_NOTFULL  = 1;
    localparam int ST_OVERFLOW    = 2;
    localparam int ST_TX_EMPTY    = 3;
    localparam int ST_RX_CNT_LSB  = 4;
    localparam int ST_TX_CNT_LSB  = 8;
    localparam int ST_IE_LSB      = 12;

    // Interrupt-enable bit positions within a STATUS write word.
    localparam int WR_IE_RX = 4;
    localparam int WR_IE_TX = 5;

endpackage

// File: rtl/b16_io_responder_fifo.sv
// 8-bit synchronous FIFO, depth 2**AW, with occupancy count. Head reads 0 when
// empty; push on full is accepted only if a pop happens in the same cycle.
module b16_io_responder_fifo
    import b16_io_responder_pkg::*;
#(
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [7:0]    din,
    input  logic          pop,
    output logic [7:0]    dout,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    localparam int DEPTH = 1 << AW;

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign full      = (r_count == (AW+1)'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign w_do_pop  = pop & ~empty;
    assign w_do_push = push & (~full | w_do_pop);
    assign dout      = empty ? 8'h00 : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_do_push & ~w_do_pop) begin
                r_count <= r_count + (AW+1)'(1);
            end else if (w_do_pop & ~w_do_push) begin
                r_count <= r_count - (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/b16_io_responder.sv
// Memory-mapped UART bridge on the b16 bus: DATA/STATUS registers in the top
// I/O page, RX/TX byte FIFOs, ready/stall. B16_IO_IRQ_EN adds the irq output.
module b16_io_responder
    import b16_io_responder_pkg::*;
#(
    parameter logic [15:0] BASE    = BASE_DEFAULT,
    parameter int          FIFO_AW = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] addr,
    input  logic        r,
    input  logic [1:0]  w,
    input  logic [15:0] dwrite,
    output logic [15:0] rdata,
    output logic        ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid
`ifdef B16_IO_IRQ_EN
    ,
    output logic        irq
`endif
);

    logic               w_cs, w_sel_status;
    logic               w_data_rd, w_data_wr, w_stat_wr;
    logic               w_rd_done, w_wr_done;
    logic               w_rx_full, w_rx_empty, w_rx_push, w_rx_pop;
    logic               w_tx_full, w_tx_empty, w_tx_push, w_tx_pop;
    logic [FIFO_AW:0]   w_rx_count, w_tx_count;
    logic [7:0]         w_rx_dout, w_rx_head;
    logic               w_rx_bypass, w_rx_avail;
    logic               w_ovf_set, w_ovf_clr;
    logic [15:0]        w_status;
    logic               r_overflow;
    logic               w_unused;

    assign w_cs         = (addr[15:2] == BASE[15:2]);
    assign w_sel_status = (addr[1] == OFS_STATUS[1]);
    assign w_data_rd    = w_cs & r & ~w_sel_status;
    assign w_data_wr    = w_cs & w[0] & ~w_sel_status;
    assign w_stat_wr    = w_cs & w[0] & w_sel_status;

    // A byte arriving while RX is empty is handed straight to a waiting read.
    assign w_rx_bypass = w_rx_empty & rx_valid;
    assign w_rx_avail  = ~w_rx_empty | rx_valid;
    assign w_rx_head   = w_rx_bypass ? rx_data : w_rx_dout;

    assign ready     = ~((w_data_rd & ~w_rx_avail) | (w_data_wr & w_tx_full));
    assign w_rd_done = w_data_rd & ready;
    assign w_wr_done = w_data_wr & ready;

    assign w_rx_pop  = w_rd_done & ~w_rx_bypass;
    assign w_rx_push = rx_valid & ~(w_rd_done & w_rx_bypass) & (~w_rx_full | w_rx_pop);
    assign w_ovf_set = rx_valid & w_rx_full & ~w_rx_pop;
    assign w_ovf_clr = w_stat_wr & dwrite[ST_OVERFLOW];

    assign w_tx_push = w_wr_done;
    assign w_tx_pop  = tx_valid & tx_ready;
    assign tx_valid  = ~w_tx_empty;

    b16_io_responder_fifo #(.AW(FIFO_AW)) u_rx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_rx_push),
        .din   (rx_data),
        .pop   (w_rx_pop),
        .dout  (w_rx_dout),
        .full  (w_rx_full),
        .empty (w_rx_empty),
        .count (w_rx_count)
    );

    b16_io_responder_fifo #(.AW(FIFO_AW)) u_tx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_tx_push),
        .din   (dwrite[7:0]),
        .pop   (w_tx_pop),
        .dout  (tx_data),
        .full  (w_tx_full),
        .empty (w_tx_empty),
        .count (w_tx_count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (w_ovf_set) begin
            r_overflow <= 1'b1;
        end else if (w_ovf_clr) begin
            r_overflow <= 1'b0;
        end
    end

`ifdef B16_IO_IRQ_EN
    logic r_ie_rx, r_ie_tx, r_irq;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ie_rx <= 1'b0;
            r_ie_tx <= 1'b0;
            r_irq   <= 1'b0;
        end else begin
            if (w_stat_wr) begin
                r_ie_rx <= dwrite[WR_IE_RX];
                r_ie_tx <= dwrite[WR_IE_TX];
            end
            r_irq <= (r_ie_rx & ~w_rx_empty) | (r_ie_tx & w_tx_empty) | r_overflow;
        end
    end

    assign irq = r_irq;
`endif

    always_comb begin
        w_status = '0;
        w_status[ST_RX_NONEMPTY] = ~w_rx_empty;
        w_status[ST_TX_NOTFULL]  = ~w_tx_full;
        w_status[ST_OVERFLOW]    = r_overflow;
        w_status[ST_TX_EMPTY]    = w_tx_empty;
        w_status[ST_RX_CNT_LSB +: 4] = 4'(w_rx_count);
        w_status[ST_TX_CNT_LSB +: 4] = 4'(w_tx_count);
`ifdef B16_IO_IRQ_EN
        w_status[ST_IE_LSB +: 2] = {r_ie_tx, r_ie_rx};
`endif
    end

    always_comb begin
        rdata = '0;
        if (w_cs & r) begin
            rdata = w_sel_status ? w_status : {8'h00, w_rx_head};
        end
    end

    assign w_unused = ^{addr[0], w[1], dwrite};

endmodule

// File: tb/tb_b16_io_responder.sv
// Directed bench for b16_io_responder with RX/TX scoreboard queues.
module tb_b16_io_responder;

    logic        clk;
    logic        reset;
    logic [15:0] addr;
    logic        r;
    logic [1:0]  w;
    logic [15:0] dwrite;
    logic [15:0] rdata;
    logic        ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
`ifdef B16_IO_IRQ_EN
    logic        irq;
`endif

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] rx_q[$];
    logic [7:0] tx_q[$];

    localparam logic [15:0] A_DATA   = 16'hFFFC;
    localparam logic [15:0] A_STATUS = 16'hFFFE;

    b16_io_responder dut (
        .clk      (clk),
        .reset    (reset),
        .addr     (addr),
        .r        (r),
        .w        (w),
        .dwrite   (dwrite),
        .rdata    (rdata),
        .ready    (ready),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid)
`ifdef B16_IO_IRQ_EN
        ,
        .irq      (irq)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        addr   = 16'h0000;
        r      = 1'b0;
        w      = 2'b00;
        dwrite = 16'h0000;
    endtask

    task automatic read_status(input string tag, input logic [15:0] exp);
        addr = A_STATUS;
        r    = 1'b1;
        #1;
        check(tag, rdata, exp);
        check({tag, "_ready"}, {15'b0, ready}, 16'h0001);
        tick();
        bus_idle();
    endtask

    task automatic write_reg(input logic [15:0] a, input logic [15:0] d);
        addr   = a;
        w      = 2'b01;
        dwrite = d;
        tick();
        bus_idle();
    endtask

    task automatic rx_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic drain_rx(input string tag, input int n);
        addr = A_DATA;
        r    = 1'b1;
        for (int i = 0; i < n; i++) begin
            #1;
            check({tag, "_ready"}, {15'b0, ready}, 16'h0001);
            check({tag, "_data"}, rdata, {8'h00, rx_q.pop_front()});
            tick();
        end
        bus_idle();
    endtask

    initial begin
        bus_idle();
        tx_ready = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        reset    = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("rst_ready", {15'b0, ready}, 16'h0001);
        check("rst_rdata", rdata, 16'h0000);
        check("rst_tx_valid", {15'b0, tx_valid}, 16'h0000);
        read_status("rst_status", 16'h000A);

        // Unselected and high-byte-only accesses have no effect.
        addr = 16'h1234; r = 1'b1; w = 2'b01; dwrite = 16'h0055;
        #1;
        check("nosel_rdata", rdata, 16'h0000);
        check("nosel_ready", {15'b0, ready}, 16'h0001);
        tick();
        addr = A_DATA; r = 1'b0; w = 2'b10; dwrite = 16'h6600;
        #1;
        check("hibyte_ready", {15'b0, ready}, 16'h0001);
        tick();
        bus_idle();
        check("nopush_tx_valid", {15'b0, tx_valid}, 16'h0000);

        // Single TX byte.
        addr = A_DATA; w = 2'b01; dwrite = 16'h0041;
        #1;
        check("tx1_ready", {15'b0, ready}, 16'h0001);
        tick();
        tx_q.push_back(8'h41);
        bus_idle();
        check("tx1_valid", {15'b0, tx_valid}, 16'h0001);
        check("tx1_data", {8'h00, tx_data}, {8'h00, tx_q[0]});
        read_status("tx1_status", 16'h0102);
        tx_ready = 1'b1;
        tick();
        void'(tx_q.pop_front());
        tx_ready = 1'b0;
        check("tx1_drained", {15'b0, tx_valid}, 16'h0000);

        // Fill TX, ninth write stalls until one byte leaves.
        for (int i = 0; i < 8; i++) begin
            addr = A_DATA; w = 2'b01; dwrite = 16'h0010 + 16'(i);
            #1;
            check("txfill_ready", {15'b0, ready}, 16'h0001);
            tick();
            tx_q.push_back(8'h10 + 8'(i));
        end
        dwrite = 16'h0018;
        #1;
        check("txfull_stall0", {15'b0, ready}, 16'h0000);
        tick();
        check("txfull_stall1", {15'b0, ready}, 16'h0000);
        tx_ready = 1'b1;
        #1;
        check("txfull_stall2", {15'b0, ready}, 16'h0000);
        check("txfull_head", {8'h00, tx_data}, {8'h00, tx_q[0]});
        tick();
        void'(tx_q.pop_front());
        tx_ready = 1'b0;
        #1;
        check("txfull_release", {15'b0, ready}, 16'h0001);
        tick();
        tx_q.push_back(8'h18);
        bus_idle();
        read_status("txfull_status", 16'h0800);
        tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("txdrain_valid", {15'b0, tx_valid}, 16'h0001);
            check("txdrain_data", {8'h00, tx_data}, {8'h00, tx_q.pop_front()});
            tick();
        end
        tx_ready = 1'b0;
        check("txdrain_empty", {15'b0, tx_valid}, 16'h0000);

        // DATA read on empty RX stalls, then takes an arriving byte directly.
        addr = A_DATA; r = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("rxwait_stall", {15'b0, ready}, 16'h0000);
            tick();
        end
        rx_valid = 1'b1; rx_data = 8'h5A;
        rx_q.push_back(8'h5A);
        #1;
        check("rxwait_ready", {15'b0, ready}, 16'h0001);
        check("rxwait_data", rdata, {8'h00, rx_q.pop_front()});
        tick();
        rx_valid = 1'b0;
        bus_idle();
        read_status("rxwait_status", 16'h000A);

        // RX overflow: ninth byte dropped, order of first eight kept.
        for (int i = 0; i < 9; i++) begin
            if (i < 8) rx_q.push_back(8'hA0 + 8'(i));
            rx_byte(8'hA0 + 8'(i));
        end
        read_status("ovf_status", 16'h008F);
        drain_rx("ovf_drain", 8);
        read_status("ovf_drained", 16'h000E);
        write_reg(A_STATUS, 16'h0004);
        read_status("ovf_cleared", 16'h000A);

        // Overflow set and clear in the same cycle: set wins.
        for (int i = 0; i < 8; i++) begin
            rx_q.push_back(8'hB0 + 8'(i));
            rx_byte(8'hB0 + 8'(i));
        end
        addr = A_STATUS; w = 2'b01; dwrite = 16'h0004;
        rx_valid = 1'b1; rx_data = 8'hEE;
        tick();
        rx_valid = 1'b0;
        bus_idle();
        read_status("setwins_status", 16'h008F);
        write_reg(A_STATUS, 16'h0004);
        read_status("setwins_cleared", 16'h008B);

        // Pop and push together on a full RX: push accepted, no overflow.
        addr = A_DATA; r = 1'b1;
        rx_valid = 1'b1; rx_data = 8'hCC;
        rx_q.push_back(8'hCC);
        #1;
        check("fullpp_data", rdata, {8'h00, rx_q.pop_front()});
        tick();
        rx_valid = 1'b0;
        bus_idle();
        read_status("fullpp_status", 16'h008B);
        drain_rx("fullpp_drain", 8);
        read_status("fullpp_empty", 16'h000A);

`ifdef B16_IO_IRQ_EN
        write_reg(A_STATUS, 16'h0010);
        check("irq_idle", {15'b0, irq}, 16'h0000);
        rx_q.push_back(8'h77);
        rx_byte(8'h77);
        check("irq_push_edge", {15'b0, irq}, 16'h0000);
        tick();
        check("irq_set", {15'b0, irq}, 16'h0001);
        read_status("irq_status", 16'h101B);
        addr = A_DATA; r = 1'b1;
        #1;
        check("irq_rd_data", rdata, {8'h00, rx_q.pop_front()});
        tick();
        bus_idle();
        check("irq_pop_edge", {15'b0, irq}, 16'h0001);
        tick();
        check("irq_clear", {15'b0, irq}, 16'h0000);
`endif

        // Reset asserted while a DATA read is stalled and TX holds a byte.
        write_reg(A_DATA, 16'h0099);
        addr = A_DATA; r = 1'b1;
        #1;
        check("midrst_stall", {15'b0, ready}, 16'h0000);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus_idle();
        rx_q.delete();
        tx_q.delete();
        #1;
        check("midrst_ready", {15'b0, ready}, 16'h0001);
        check("midrst_tx_valid", {15'b0, tx_valid}, 16'h0000);
        read_status("midrst_status", 16'h000A);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
